lsb_queue: RTL and testbench

Parametrised in-order load/store queue for the Tomasulo core. It accepts decoded load and store ops from the issue stage and captures operands from the register file. It snoops the CDB for missing operands and issues memory accesses to the cache strictly from the head in program order. Stores go to memory only after the ROB commits them; misprediction flush discards speculative entries, and loads finish by broadcasting to the ROB.

---
 rtl/lsb_queue_pkg.sv | 45 ++++
 rtl/lsb_entry_snoop.sv | 35 +++
 rtl/lsb_queue.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_queue_pkg.sv
// Shared definitions for the load/store queue: opcodes, access-type encodings, FSM states
// and the dispatch-side opcode decoder.
package lsb_queue_pkg;

  localparam logic [4:0] OpLb  = 5'd0;
  localparam logic [4:0] OpLh  = 5'd1;
  localparam logic [4:0] OpLw  = 5'd2;
  localparam logic [4:0] OpLbu = 5'd3;
  localparam logic [4:0] OpLhu = 5'd4;
  localparam logic [4:0] OpSb  = 5'd5;
  localparam logic [4:0] OpSh  = 5'd6;
  localparam logic [4:0] OpSw  = 5'd7;

  // type[1:0]: 00 word, 01 half, 10 byte; type[2]: sign-extend
  localparam logic [2:0] TypeWord   = 3'b000;
  localparam logic [2:0] TypeHalf   = 3'b001;
  localparam logic [2:0] TypeByte   = 3'b010;
  localparam logic [2:0] TypeSigned = 3'b100;

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} lsb_state_e;

  typedef struct packed {
    logic       is_ls;
    logic       is_load;
    logic [2:0] mem_type;
  } op_decode_t;

  function automatic op_decode_t decode_op(input logic [4:0] op);
    op_decode_t d;
    d = '{is_ls: 1'b1, is_load: 1'b1, mem_type: TypeWord};
    case (op)
      OpLb:    d.mem_type = TypeSigned | TypeByte;
      OpLh:    d.mem_type = TypeSigned | TypeHalf;
      OpLw:    d.mem_type = TypeWord;
      OpLbu:   d.mem_type = TypeByte;
      OpLhu:   d.mem_type = TypeHalf;
      OpSb:    begin d.is_load = 1'b0; d.mem_type = TypeByte; end
      OpSh:    begin d.is_load = 1'b0; d.mem_type = TypeHalf; end
      OpSw:    begin d.is_load = 1'b0; d.mem_type = TypeWord; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsb_entry_snoop.sv
// Per-entry CDB wakeup: replaces a waiting operand with the broadcast value and clears its tag.
module lsb_entry_snoop
  import lsb_queue_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic             entry_valid,
  input  logic             cdb_active,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_val,
  input  logic [TAG_W-1:0] qj,
  input  logic [TAG_W-1:0] qk,
  input  logic [XLEN-1:0]  vj,
  input  logic [XLEN-1:0]  vk,
  output logic [TAG_W-1:0] qj_upd,
  output logic [TAG_W-1:0] qk_upd,
  output logic [XLEN-1:0]  vj_upd,
  output logic [XLEN-1:0]  vk_upd
);

  localparam logic [TAG_W-1:0] TagNone = '1;

  logic hit_j, hit_k;

  // An operand already holding "no tag" must never match a broadcast.
  assign hit_j = entry_valid && cdb_active && (qj != TagNone) && (qj == cdb_tag);
  assign hit_k = entry_valid && cdb_active && (qk != TagNone) && (qk == cdb_tag);

  assign qj_upd = hit_j ? TagNone : qj;
  assign vj_upd = hit_j ? cdb_val : vj;
  assign qk_upd = hit_k ? TagNone : qk;
  assign vk_upd = hit_k ? cdb_val : vk;

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store queue: dispatch at tail, CDB snoop, head-only cache access, flush.
// Build option LSB_BYPASS_EN lets a dispatching op capture a same-cycle CDB broadcast.
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TAG_BASE = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   inst_valid,
  input  logic [4:0]             op,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        vj,
  input  logic [XLEN-1:0]        vk,
  input  logic [TAG_W-1:0]       qj,
  input  logic [TAG_W-1:0]       qk,
  output logic                   launch_fail,
  output logic [TAG_W-1:0]       choose_tag,
  input  logic                   cdb_active,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [XLEN-1:0]        cdb_val,
  input  logic                   commit_valid,
  input  logic                   flush,
  output logic                   activate_cache,
  output logic                   r_nw_out,
  output logic [2:0]             type_out,
  output logic [XLEN-1:0]        ls_addr,
  output logic [XLEN-1:0]        st_val,
  input  logic [XLEN-1:0]        ld_val,
  input  logic                   ls_done_in,
  output logic                   submit_valid,
  output logic [TAG_W-1:0]       submit_tag,
  output logic [XLEN-1:0]        submit_val,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [TAG_W-1:0] TagNone = '1;
  localparam logic [TAG_W-1:0] TagBase = TAG_W'(TAG_BASE);

  logic [DEPTH-1:0] valid_q, committed_q, is_load_q;
  logic [2:0]       mem_type_q [DEPTH];
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  vj_q [DEPTH];
  logic [XLEN-1:0]  vk_q [DEPTH];
  logic [TAG_W-1:0] qj_q [DEPTH];
  logic [TAG_W-1:0] qk_q [DEPTH];
  logic [TAG_W-1:0] qj_upd [DEPTH];
  logic [TAG_W-1:0] qk_upd [DEPTH];
  logic [XLEN-1:0]  vj_upd [DEPTH];
  logic [XLEN-1:0]  vk_upd [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  lsb_state_e    state_q, state_d;

  logic            req_r_nw_q;
  logic [2:0]      req_type_q;
  logic [XLEN-1:0] req_addr_q, req_st_val_q;

  logic             submit_valid_q, submit_valid_d;
  logic [TAG_W-1:0] submit_tag_q;
  logic [XLEN-1:0]  submit_val_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    lsb_entry_snoop #(
      .TAG_W (TAG_W),
      .XLEN  (XLEN)
    ) u_snoop (
      .entry_valid (valid_q[i]),
      .cdb_active  (cdb_active),
      .cdb_tag     (cdb_tag),
      .cdb_val     (cdb_val),
      .qj          (qj_q[i]),
      .qk          (qk_q[i]),
      .vj          (vj_q[i]),
      .vk          (vk_q[i]),
      .qj_upd      (qj_upd[i]),
      .qk_upd      (qk_upd[i]),
      .vj_upd      (vj_upd[i]),
      .vk_upd      (vk_upd[i])
    );
  end

  op_decode_t dec;
  logic       full, push, head_ready, fire, done;
  logic [TAG_W-1:0] head_tag;

  assign dec         = decode_op(op);
  assign full        = (count_q == CW'(DEPTH));
  assign push        = rdy_in && !flush && inst_valid && dec.is_ls && !full;
  assign launch_fail = inst_valid && dec.is_ls && full;
  assign choose_tag  = push ? TagBase + TAG_W'(tail_q) : TagNone;
  assign head_tag    = TagBase + TAG_W'(head_q);

  assign head_ready = valid_q[head_q] && (qj_q[head_q] == TagNone) &&
                      (qk_q[head_q] == TagNone) && (is_load_q[head_q] || committed_q[head_q]);
  assign fire       = rdy_in && !flush && (state_q == StIdle) && head_ready;
  assign done       = rdy_in && ls_done_in && (state_q != StIdle);

  // Operands for the entry being written at tail.
  logic [TAG_W-1:0] new_qj, new_qk;
  logic [XLEN-1:0]  new_vj, new_vk;

  always_comb begin
    new_qj = qj;
    new_vj = vj;
    new_qk = dec.is_load ? TagNone : qk;
    new_vk = vk;
`ifdef LSB_BYPASS_EN
    if (cdb_active && (new_qj != TagNone) && (new_qj == cdb_tag)) begin
      new_qj = TagNone;
      new_vj = cdb_val;
    end
    if (cdb_active && (new_qk != TagNone) && (new_qk == cdb_tag)) begin
      new_qk = TagNone;
      new_vk = cdb_val;
    end
`endif
  end

  // Oldest valid uncommitted store, searched from head.
  logic          commit_hit;
  logic [PW-1:0] commit_idx, scan_idx;

  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!commit_hit && valid_q[scan_idx] && !is_load_q[scan_idx] && !committed_q[scan_idx]) begin
        commit_hit = 1'b1;
        commit_idx = scan_idx;
      end
    end
  end

  // Flush keeps committed stores; an in-flight uncommitted head keeps its slot reserved.
  logic [CW-1:0] kept, flush_count;
  logic [PW-1:0] flush_head, flush_tail;
  logic          reserve;

  always_comb begin
    kept = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kept = kept + CW'(valid_q[i] & committed_q[i]);
    end
    if (done && (state_q == StBusy) && committed_q[head_q]) begin
      kept = kept - CW'(1);
    end
    reserve     = (state_q != StIdle) && !done &&
                  !((state_q == StBusy) && committed_q[head_q]);
    flush_head  = head_q + PW'(done);
    flush_count = kept + CW'(reserve);
    flush_tail  = flush_head + flush_count[PW-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fire) state_d = StBusy;
      StBusy: begin
        if (done) begin
          state_d = StIdle;
        end else if (flush && !committed_q[head_q]) begin
          state_d = StDrain;
        end
      end
      StDrain: if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign submit_valid_d = done && (state_q == StBusy) && is_load_q[head_q] && !flush;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      committed_q <= '0;
      is_load_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_type_q[i] <= '0;
        imm_q[i]      <= '0;
        vj_q[i]       <= '0;
        vk_q[i]       <= '0;
        qj_q[i]       <= TagNone;
        qk_q[i]       <= TagNone;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= StIdle;
      req_r_nw_q     <= 1'b0;
      req_type_q     <= '0;
      req_addr_q     <= '0;
      req_st_val_q   <= '0;
      submit_valid_q <= 1'b0;
      submit_tag_q   <= TagNone;
      submit_val_q   <= '0;
    end else if (rdy_in) begin
      state_q        <= state_d;
      submit_valid_q <= submit_valid_d;
      submit_tag_q   <= submit_valid_d ? head_tag : TagNone;
      submit_val_q   <= submit_valid_d ? ld_val : '0;
      if (fire) begin
        req_r_nw_q   <= is_load_q[head_q];
        req_type_q   <= mem_type_q[head_q];
        req_addr_q   <= vj_q[head_q] + imm_q[head_q];
        req_st_val_q <= vk_q[head_q];
      end
      if (flush) begin
        valid_q <= valid_q & committed_q;
        if (done) begin
          valid_q[head_q]     <= 1'b0;
          committed_q[head_q] <= 1'b0;
        end
        head_q  <= flush_head;
        tail_q  <= flush_tail;
        count_q <= flush_count;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          qj_q[i] <= qj_upd[i];
          qk_q[i] <= qk_upd[i];
          vj_q[i] <= vj_upd[i];
          vk_q[i] <= vk_upd[i];
        end
        if (commit_hit && commit_valid) committed_q[commit_idx] <= 1'b1;
        if (done) begin
          valid_q[head_q]     <= 1'b0;
          committed_q[head_q] <= 1'b0;
        end
        if (push) begin
          valid_q[tail_q]     <= 1'b1;
          committed_q[tail_q] <= 1'b0;
          is_load_q[tail_q]   <= dec.is_load;
          mem_type_q[tail_q]  <= dec.mem_type;
          imm_q[tail_q]       <= imm;
          qj_q[tail_q]        <= new_qj;
          qk_q[tail_q]        <= new_qk;
          vj_q[tail_q]        <= new_vj;
          vk_q[tail_q]        <= new_vk;
        end
        head_q  <= head_q + PW'(done);
        tail_q  <= tail_q + PW'(push);
        count_q <= count_q + CW'(push) - CW'(done);
      end
    end
  end

  // Request fields come straight from the head in the request cycle, then from the latch.
  always_comb begin
    r_nw_out = 1'b0;
    type_out = '0;
    ls_addr  = '0;
    st_val   = '0;
    if (fire) begin
      r_nw_out = is_load_q[head_q];
      type_out = mem_type_q[head_q];
      ls_addr  = vj_q[head_q] + imm_q[head_q];
      st_val   = vk_q[head_q];
    end else if (state_q != StIdle) begin
      r_nw_out = req_r_nw_q;
      type_out = req_type_q;
      ls_addr  = req_addr_q;
      st_val   = req_st_val_q;
    end
  end

  assign activate_cache = fire;
  assign submit_valid   = submit_valid_q && rdy_in;
  assign submit_tag     = submit_tag_q;
  assign submit_val     = submit_val_q;
  assign count          = count_q;

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: dispatch, CDB wakeup, commit, full, flush, drain, stall, wrap.
module tb_lsb_queue;
  import lsb_queue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, inst_valid;
  logic [4:0]  op;
  logic [31:0] imm, vj, vk;
  logic [3:0]  qj, qk;
  logic        launch_fail;
  logic [3:0]  choose_tag;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        commit_valid, flush;
  logic        activate_cache, r_nw_out;
  logic [2:0]  type_out;
  logic [31:0] ls_addr, st_val, ld_val;
  logic        ls_done_in;
  logic        submit_valid;
  logic [3:0]  submit_tag;
  logic [31:0] submit_val;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_in = ~clk_in;

  lsb_queue #(
    .DEPTH    (8),
    .TAG_W    (4),
    .TAG_BASE (4),
    .XLEN     (32)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .inst_valid     (inst_valid),
    .op             (op),
    .imm            (imm),
    .vj             (vj),
    .vk             (vk),
    .qj             (qj),
    .qk             (qk),
    .launch_fail    (launch_fail),
    .choose_tag     (choose_tag),
    .cdb_active     (cdb_active),
    .cdb_tag        (cdb_tag),
    .cdb_val        (cdb_val),
    .commit_valid   (commit_valid),
    .flush          (flush),
    .activate_cache (activate_cache),
    .r_nw_out       (r_nw_out),
    .type_out       (type_out),
    .ls_addr        (ls_addr),
    .st_val         (st_val),
    .ld_val         (ld_val),
    .ls_done_in     (ls_done_in),
    .submit_valid   (submit_valid),
    .submit_tag     (submit_tag),
    .submit_val     (submit_val),
    .count          (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    inst_valid   = 1'b0;
    op           = OpLw;
    imm          = '0;
    vj           = '0;
    vk           = '0;
    qj           = 4'hF;
    qk           = 4'hF;
    cdb_active   = 1'b0;
    cdb_tag      = 4'hF;
    cdb_val      = '0;
    commit_valid = 1'b0;
    flush        = 1'b0;
    ld_val       = '0;
    ls_done_in   = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] o, input logic [31:0] i_imm, input logic [31:0] i_vj,
                          input logic [31:0] i_vk, input logic [3:0] i_qj, input logic [3:0] i_qk);
    inst_valid = 1'b1;
    op         = o;
    imm        = i_imm;
    vj         = i_vj;
    vk         = i_vk;
    qj         = i_qj;
    qk         = i_qk;
  endtask

  task automatic do_reset();
    clear_inputs();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    rdy_in = 1'b1;
    rst_in = 1'b1;
    clear_inputs();

    // Reset state
    do_reset();
    #1;
    check_eq("rst_count", count, 0);
    check_eq("rst_act", activate_cache, 0);
    check_eq("rst_submit", submit_valid, 0);
    check_eq("rst_submit_tag", submit_tag, 4'hF);
    check_eq("rst_choose_tag", choose_tag, 4'hF);
    check_eq("rst_launch_fail", launch_fail, 0);
    check_eq("rst_addr", ls_addr, 0);

    // LW: issue next cycle, result broadcast after ls_done_in
    do_reset();
    dispatch(OpLw, 32'd4, 32'h100, 32'h0, 4'hF, 4'hF);
    #1;
    check_eq("lw_tag", choose_tag, 4);
    check_eq("lw_fail", launch_fail, 0);
    step();
    clear_inputs();
    #1;
    check_eq("lw_act", activate_cache, 1);
    check_eq("lw_addr", ls_addr, 32'h104);
    check_eq("lw_rnw", r_nw_out, 1);
    check_eq("lw_type", type_out, 3'b000);
    check_eq("lw_count", count, 1);
    step();
    check_eq("lw_act_pulse", activate_cache, 0);
    check_eq("lw_addr_hold", ls_addr, 32'h104);
    ls_done_in = 1'b1;
    ld_val     = 32'hDEADBEEF;
    step();
    clear_inputs();
    #1;
    check_eq("lw_sub_v", submit_valid, 1);
    check_eq("lw_sub_tag", submit_tag, 4);
    check_eq("lw_sub_val", submit_val, 32'hDEADBEEF);
    check_eq("lw_count0", count, 0);
    step();
    check_eq("lw_sub_pulse", submit_valid, 0);

    // SW waiting on tag 6, woken by CDB, issued only after commit
    do_reset();
    dispatch(OpSw, 32'd0, 32'h200, 32'h0, 4'hF, 4'd6);
    #1;
    check_eq("sw_tag", choose_tag, 4);
    step();
    clear_inputs();
    cdb_active = 1'b1;
    cdb_tag    = 4'd6;
    cdb_val    = 32'h55;
    #1;
    check_eq("sw_no_act0", activate_cache, 0);
    step();
    clear_inputs();
    #1;
    check_eq("sw_no_act1", activate_cache, 0);
    step();
    commit_valid = 1'b1;
    #1;
    check_eq("sw_no_act2", activate_cache, 0);
    step();
    clear_inputs();
    #1;
    check_eq("sw_act", activate_cache, 1);
    check_eq("sw_rnw", r_nw_out, 0);
    check_eq("sw_stval", st_val, 32'h55);
    check_eq("sw_addr", ls_addr, 32'h200);
    step();
    ls_done_in = 1'b1;
    step();
    clear_inputs();
    #1;
    check_eq("sw_no_submit", submit_valid, 0);
    check_eq("sw_count0", count, 0);

    // Fill all 8 entries, then a 9th LB is refused
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dispatch(OpLw, 32'd0, 32'd0, 32'd0, 4'd9, 4'hF);
      #1;
      check_eq("full_tag", choose_tag, 32'(4 + i));
      step();
    end
    dispatch(OpLb, 32'd0, 32'd0, 32'd0, 4'd9, 4'hF);
    #1;
    check_eq("full_fail", launch_fail, 1);
    check_eq("full_tag_none", choose_tag, 4'hF);
    step();
    clear_inputs();
    #1;
    check_eq("full_count", count, 8);
    check_eq("full_no_act", activate_cache, 0);

    // Committed SH at head plus two stalled loads, then flush
    do_reset();
    dispatch(OpSh, 32'd2, 32'h300, 32'hABCD, 4'hF, 4'hF);
    step();
    dispatch(OpLw, 32'd0, 32'd0, 32'd0, 4'd9, 4'hF);
    step();
    dispatch(OpLw, 32'd0, 32'd0, 32'd0, 4'd9, 4'hF);
    commit_valid = 1'b1;
    step();
    clear_inputs();
    flush = 1'b1;
    #1;
    check_eq("fl_count3", count, 3);
    check_eq("fl_no_act", activate_cache, 0);
    step();
    clear_inputs();
    #1;
    check_eq("fl_count1", count, 1);
    check_eq("fl_act", activate_cache, 1);
    check_eq("fl_rnw", r_nw_out, 0);
    check_eq("fl_type", type_out, 3'b001);
    check_eq("fl_addr", ls_addr, 32'h302);
    check_eq("fl_stval", st_val, 32'hABCD);
    step();
    ls_done_in = 1'b1;
    step();
    clear_inputs();
    dispatch(OpLw, 32'd0, 32'd0, 32'd0, 4'hF, 4'hF);
    #1;
    check_eq("fl_count0", count, 0);
    check_eq("fl_no_submit", submit_valid, 0);
    check_eq("fl_next_tag", choose_tag, 5);

    // Flush while a load is in flight: drain, no submit, freed tag reused
    do_reset();
    dispatch(OpLw, 32'd0, 32'h40, 32'd0, 4'hF, 4'hF);
    step();
    dispatch(OpLw, 32'd0, 32'h80, 32'd0, 4'hF, 4'hF);
    #1;
    check_eq("dr_act", activate_cache, 1);
    check_eq("dr_tag5", choose_tag, 5);
    step();
    clear_inputs();
    flush = 1'b1;
    step();
    clear_inputs();
    #1;
    check_eq("dr_count_res", count, 1);
    check_eq("dr_no_act", activate_cache, 0);
    step();
    step();
    ls_done_in = 1'b1;
    ld_val     = 32'h77;
    step();
    clear_inputs();
    dispatch(OpLw, 32'd8, 32'h500, 32'd0, 4'hF, 4'hF);
    #1;
    check_eq("dr_no_submit", submit_valid, 0);
    check_eq("dr_count0", count, 0);
    check_eq("dr_no_act2", activate_cache, 0);
    check_eq("dr_reuse_tag", choose_tag, 5);
    step();
    clear_inputs();
    #1;
    check_eq("dr_new_act", activate_cache, 1);
    check_eq("dr_new_addr", ls_addr, 32'h508);

    // rdy_in low freezes the queue and masks the request pulse
    do_reset();
    dispatch(OpLw, 32'd0, 32'h10, 32'd0, 4'hF, 4'hF);
    step();
    clear_inputs();
    rdy_in = 1'b0;
    #1;
    check_eq("rdy_mask", activate_cache, 0);
    step();
    step();
    rdy_in = 1'b1;
    #1;
    check_eq("rdy_act", activate_cache, 1);
    check_eq("rdy_count", count, 1);

    // Wrap: 20 loads, free and dispatch collide every other cycle
    do_reset();
    dispatch(OpLw, 32'd0, 32'd0, 32'd0, 4'hF, 4'hF);
    #1;
    check_eq("wr_tag", choose_tag, 4);
    step();
    for (int j = 0; j < 20; j++) begin
      clear_inputs();
      #1;
      check_eq("wr_act", activate_cache, 1);
      check_eq("wr_addr", ls_addr, 32'(j * 16));
      if (j > 0) begin
        check_eq("wr_sub_v", submit_valid, 1);
        check_eq("wr_sub_tag", submit_tag, 32'(4 + ((j - 1) % 8)));
        check_eq("wr_sub_val", submit_val, 32'(32'h1000 + j - 1));
      end
      step();
      ls_done_in = 1'b1;
      ld_val     = 32'(32'h1000 + j);
      if (j < 19) dispatch(OpLw, 32'd0, 32'((j + 1) * 16), 32'd0, 4'hF, 4'hF);
      #1;
      if (j < 19) check_eq("wr_tag", choose_tag, 32'(4 + ((j + 1) % 8)));
      check_eq("wr_count", count, 1);
      step();
    end
    clear_inputs();
    #1;
    check_eq("wr_last_v", submit_valid, 1);
    check_eq("wr_last_tag", submit_tag, 7);
    check_eq("wr_last_val", submit_val, 32'h1013);
    check_eq("wr_count0", count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
